// File: rtl/struct_union_pkg.sv
// struct_union_pkg: shared instruction/operand types for the struct_union_alu datapath.
package struct_union_pkg;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {add, sub, mul, div, sl, sr} opcode_t;

    typedef enum logic [31:0] {sign = 32'd0, unsign = 32'd1} operand_type_t;

    typedef union packed {
        logic        [DATA_W-1:0] u_data;
        logic signed [DATA_W-1:0] s_data;
    } data_t;

    typedef union packed {
        logic        [2*DATA_W-1:0] u_data;
        logic signed [2*DATA_W-1:0] s_data;
    } l_data_t;

    typedef struct packed {
        opcode_t       opr;
        operand_type_t opr_type;
        data_t         opr_a;
        data_t         opr_b;
    } instr_t;
endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: combinational compute of one instr_t into a 64-bit result.
module alu_comb_core
    import struct_union_pkg::*;
(
    input  instr_t  instr,
    output l_data_t res
);
    logic               is_s;
    logic               b_zero;
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [32:0] a33;
    logic signed [32:0] d33;
    logic signed [32:0] q33;
    logic        [4:0]  sh;

    always_comb begin
        res    = '0;
        is_s   = instr.opr_type == 32'd0;
        b_zero = instr.opr_b.u_data == '0;
        sh     = instr.opr_b.u_data[4:0];
        a_ext  = is_s ? 64'(instr.opr_a.s_data) : 64'(instr.opr_a.u_data);
        b_ext  = is_s ? 64'(instr.opr_b.s_data) : 64'(instr.opr_b.u_data);
        // 33 bits hold both the unsigned range and +2^31 from -2^31 / -1
        a33    = a_ext[32:0];
        d33    = b_zero ? 33'sd1 : b_ext[32:0];
        q33    = a33 / d33;
        res.s_data = (instr.opr == add) ? a_ext + b_ext :
                     (instr.opr == sub) ? a_ext - b_ext :
                     (instr.opr == mul) ? a_ext * b_ext :
                     (instr.opr == div) ? (b_zero ? 64'sd0 : 64'(q33)) :
                     (instr.opr == sl)  ? a_ext << sh :
                     (instr.opr == sr)  ? a_ext >>> sh : 64'sd0;
    end
endmodule

// File: rtl/struct_union_alu.sv
// struct_union_alu: registered ALU, one-cycle latency from in_valid to out_valid/result.
// Define ALU_STATUS_EN to add the registered status[2:0] output (zero, div_by_zero, illegal_op).
module struct_union_alu
    import struct_union_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  instr_t              instr,
    output logic                out_valid,
    output logic [2*DATA_W-1:0] result
`ifdef ALU_STATUS_EN
    ,
    output logic [2:0]          status
`endif
);
    l_data_t             core_res;
    logic                valid_d, valid_q;
    logic [2*DATA_W-1:0] result_d, result_q;

    alu_comb_core u_core (
        .instr (instr),
        .res   (core_res)
    );

    always_comb begin
        valid_d  = in_valid;
        result_d = in_valid ? core_res.u_data : result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;

`ifdef ALU_STATUS_EN
    logic [2:0] status_d, status_q;

    always_comb begin
        status_d = in_valid ? {instr.opr[2] & instr.opr[1],
                               (instr.opr == div) && (instr.opr_b.u_data == '0),
                               core_res.u_data == '0} : status_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status_q <= '0;
        else        status_q <= status_d;
    end

    assign status = status_q;
`endif
endmodule

// File: tb/tb_struct_union_alu.sv
// tb_struct_union_alu: directed vector table, reset sequences and a random stream against an arithmetic model.
module tb_struct_union_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [98:0] instr = '0;
    logic        out_valid;
    logic [63:0] result;
    int          checks = 0;
    int          failures = 0;
`ifdef ALU_STATUS_EN
    logic [2:0]  status;
`endif

    struct_union_alu #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .instr     (instr),
        .out_valid (out_valid),
        .result    (result)
`ifdef ALU_STATUS_EN
        ,
        .status    (status)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] typ;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        logic [2:0]  st;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] typ,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = (typ == 0) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (typ == 0) ? longint'($signed(b)) : longint'({32'b0, b});
        case (op)
            3'd0: return sa + sb;
            3'd1: return sa - sb;
            3'd2: return sa * sb;
            3'd3: return (b == 0) ? 64'd0 : sa / sb;
            3'd4: return sa << b[4:0];
            3'd5: return sa >>> b[4:0];
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [2:0] model_st(input logic [2:0] op, input logic [31:0] b, input logic [63:0] r);
        return {op >= 3'd6, op == 3'd3 && b == 0, r == 0};
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] typ, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        instr = {op, typ, a, b};
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp, last;
        logic [2:0]  op;
        logic [31:0] typ, a, b;

        vecs[0]  = '{3'd0, 32'd0, 32'h10, 32'h20, 64'h30, 3'b000};
        vecs[1]  = '{3'd1, 32'd0, 32'h10, 32'h20, 64'hFFFF_FFFF_FFFF_FFF0, 3'b000};
        vecs[2]  = '{3'd2, 32'd0, 32'h10, 32'h20, 64'h200, 3'b000};
        vecs[3]  = '{3'd3, 32'd0, 32'h10, 32'h20, 64'h0, 3'b001};
        vecs[4]  = '{3'd4, 32'd0, 32'h10, 32'h20, 64'h10, 3'b000};
        vecs[5]  = '{3'd5, 32'd0, 32'h10, 32'h20, 64'h10, 3'b000};
        vecs[6]  = '{3'd2, 32'd0, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 3'b000};
        vecs[7]  = '{3'd2, 32'd1, 32'hFFFF_FFFE, 32'd3, 64'h2_FFFF_FFFA, 3'b000};
        vecs[8]  = '{3'd3, 32'd0, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 3'b000};
        vecs[9]  = '{3'd5, 32'd0, 32'h8000_0000, 32'd4, 64'hFFFF_FFFF_F800_0000, 3'b000};
        vecs[10] = '{3'd5, 32'd1, 32'h8000_0000, 32'd4, 64'h0800_0000, 3'b000};
        vecs[11] = '{3'd3, 32'd0, 32'h1234, 32'd0, 64'h0, 3'b011};
        vecs[12] = '{3'd3, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000, 3'b000};
        vecs[13] = '{3'd4, 32'd1, 32'hFFFF_FFFF, 32'd31, 64'h7FFF_FFFF_8000_0000, 3'b000};
        vecs[14] = '{3'd6, 32'd0, 32'h5, 32'h7, 64'h0, 3'b101};
        vecs[15] = '{3'd7, 32'd1, 32'h5, 32'h7, 64'h0, 3'b101};
        vecs[16] = '{3'd3, 32'd7, 32'hFFFF_FFF9, 32'd2, 64'h7FFF_FFFC, 3'b000};

        #2 rst_n = 1'b0;
        #1;
        chk("reset_result", result, 64'h0);
        chk("reset_valid", {63'b0, out_valid}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].typ, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_valid", i), {63'b0, out_valid}, 64'h1);
            chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
`ifdef ALU_STATUS_EN
            chk($sformatf("vec%0d_status", i), {61'b0, status}, {61'b0, vecs[i].st});
`endif
        end

        drive(3'd0, 32'd1, 32'hDEAD, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_result", result, 64'h0);
        chk("async_reset_valid", {63'b0, out_valid}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(3'd0, 32'd1, 32'h1, 32'h1);
        @(negedge clk);
        in_valid = 1'b1;
        instr = {3'd0, 32'd1, 32'h55, 32'h1};
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_discard_valid", {63'b0, out_valid}, 64'h0);
        chk("reset_discard_result", result, 64'h0);

        last = 64'h0;
        for (int i = 0; i < 10; i++) begin
            op  = 3'($urandom_range(0, 7));
            typ = ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
            a   = $urandom;
            b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            exp = model(op, typ, a, b);
            drive(op, typ, a, b);
            chk($sformatf("rand%0d_valid", i), {63'b0, out_valid}, 64'h1);
            chk($sformatf("rand%0d_result", i), result, exp);
`ifdef ALU_STATUS_EN
            chk($sformatf("rand%0d_status", i), {61'b0, status}, {61'b0, model_st(op, b, exp)});
`endif
            last = exp;
        end
        @(negedge clk);
        in_valid = 1'b0;
        instr = {3'd0, 32'd0, $urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle%0d_valid", i), {63'b0, out_valid}, 64'h0);
            chk($sformatf("idle%0d_hold", i), result, last);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/struct_union_alu.md
Name: struct_union_alu

Overview:
- Registered 32-bit ALU that takes one packed instruction word: opcode, operand type, and two 32-bit operands.
- Produces a 64-bit result one clock after a valid instruction is presented.
- Supports add, sub, mul, div, shift-left and shift-right, each in signed or unsigned mode.
- Sits as a leaf datapath block behind an instruction/operand source.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction valid; sampled on the rising edge of clk.
- instr  input  99  packed instruction: [98:96] opcode, [95:64] operand type, [63:32] operand A, [31:0] operand B.
- out_valid  output  1  high for one cycle when result is updated.
- result  output  64  registered result; each operand is viewable as unsigned or signed.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: result=0 and out_valid=0, asserted immediately without waiting for a clock edge. Reset mid-operation discards the pending instruction.
- Latency: 1 cycle. An instruction sampled with in_valid=1 at edge N appears on result with out_valid=1 after edge N. No backpressure.
- in_valid=0: out_valid=0 and result holds its previous value.
- Operand type: 0 = signed, any nonzero value = unsigned.
- Extension: signed mode sign-extends A and B to 64 bits; unsigned mode zero-extends them.
- Opcodes:
  - 0 add: ext(A)+ext(B), 64-bit.
  - 1 sub: ext(A)-ext(B), 64-bit two's complement.
  - 2 mul: full 64-bit product; signed or unsigned per type.
  - 3 div: A/B quotient, truncated toward zero, extended to 64 bits. B=0 gives result 0.
  - 4 sl: ext(A) << B[4:0], 64-bit; bits up to 63 are kept.
  - 5 sr: signed mode is arithmetic A >>> B[4:0], unsigned mode is logical A >> B[4:0]; result extended to 64 bits.
  - 6, 7 (illegal): result=0, out_valid still asserted.
- Overflow: signed div of -2^31 by -1 gives +2^31 (0x0000_0000_8000_0000). No overflow is possible with a 64-bit result.
- Back-to-back: a new instruction is accepted every cycle.

Optional Feature:
- Macro ALU_STATUS_EN. When defined, add output status[2:0], registered alongside result and cleared on reset:
  - [0] zero: result==0.
  - [1] div_by_zero: opcode div with B==0.
  - [2] illegal_op: opcode 6 or 7.
- When not defined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package struct_union_pkg holds:
  - opcode_t: 3-bit enum add, sub, mul, div, sl, sr.
  - operand_type_t: 32-bit enum sign=0, unsign=1.
  - data_t: packed union of 32-bit logic u_data and signed s_data.
  - l_data_t: the same union at 64 bits.
  - instr_t: packed struct of opr, opr_type, opr_a, opr_b, in that order, 99 bits total.
- Sub-module alu_comb_core: purely combinational compute from instr_t to l_data_t. The top level adds the valid/result registers and the optional status.

Test Plan:
- Reset: assert rst_n=0 between clock edges -> result=0 and out_valid=0 immediately. Assert reset while in_valid=1 -> no out_valid after release.
- Signed sweep with A=0x10, B=0x20, ops 0..5 -> 0x30, 0xFFFF_FFFF_FFFF_FFF0, 0x200, 0x0, 0x10 (shift amount B[4:0]=0), 0x10; each appears one cycle after in_valid.
- Signedness:
  - mul A=0xFFFF_FFFE, B=3 signed -> 0xFFFF_FFFF_FFFF_FFFA; unsigned -> 0x2_FFFF_FFFA.
  - div A=-7, B=2 signed -> 0xFFFF_FFFF_FFFF_FFFD.
  - sr A=0x8000_0000, B=4 signed -> 0xFFFF_FFFF_F800_0000; unsigned -> 0x0800_0000.
- Boundaries:
  - div B=0 -> result 0, status[1]=1 when ALU_STATUS_EN.
  - signed 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000.
  - sl A=0xFFFF_FFFF, B=31 unsigned -> 0x7FFF_FFFF_8000_0000.
- Illegal opcodes 6 and 7 -> result 0, out_valid=1, status[2]=1.
- Stream 10 random back-to-back instructions, then in_valid=0 for 3 cycles -> each result matches a reference model one cycle later; result holds and out_valid=0 while idle.
